// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional
// one-entry skid buffer, flush-to-bubble, saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       SKID      = 0,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  input  logic [WIDTH-1:0] inData,
  output logic             inReady,
  output logic             outValid,
  output logic [WIDTH-1:0] outData,
  input  logic             outReady,
  input  logic             flush,
  output logic [CNT_W-1:0] stallCount,
  output logic             skidFull
);

  logic             vld_q, vld_n;
  logic [WIDTH-1:0] dat_q, dat_n;
  logic             skv_q, skv_n;
  logic [WIDTH-1:0] skd_q, skd_n;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             drain;
  logic             stall;

  assign accept = inValid && inReady;
  assign drain  = vld_q && outReady;
  assign stall  = vld_q && !outReady && !flush;

  // Ready is gated by rstN so it reads 0 in reset and 1 right after.
  generate
    if (SKID != 0) begin : g_skid
      assign inReady = rstN && !skv_q;
    end else begin : g_noskid
      assign inReady = rstN && (!vld_q || outReady);
    end
  endgenerate

  assign outValid   = vld_q;
  assign outData    = dat_q;
  assign skidFull   = skv_q;
  assign stallCount = cnt_q;

  // Next-state for the output register and the skid entry.
  always_comb begin
    vld_n = vld_q;
    dat_n = dat_q;
    skv_n = skv_q;
    skd_n = skd_q;
    if (flush) begin
      vld_n = 1'b0;
      dat_n = NOP_VALUE;
      skv_n = 1'b0;
    end else if (skv_q) begin
      if (drain) begin
        vld_n = 1'b1;
        dat_n = skd_q;
        skv_n = accept;
        if (accept) begin
          skd_n = inData;
        end
      end
    end else if (!vld_q || drain) begin
      if (accept) begin
        vld_n = 1'b1;
        dat_n = inData;
      end else if (drain) begin
        vld_n = 1'b0;
        dat_n = NOP_VALUE;
      end
    end else if (accept) begin
      skv_n = (SKID != 0);
      skd_n = inData;
    end
  end

  // Stage state advances on the falling edge.
  always_ff @(negedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_q <= 1'b0;
      dat_q <= NOP_VALUE;
      skv_q <= 1'b0;
      skd_q <= '0;
    end else begin
      vld_q <= vld_n;
      dat_q <= dat_n;
      skv_q <= skv_n;
      skd_q <= skd_n;
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(negedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else if (stall && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
